// File: rtl/nota_word_sequencer.sv
// rtl/nota_word_sequencer.sv - buffers notes and feeds one word at a time to the note-word classifier
module nota_word_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_NOTES  = 4,
  parameter int TIMEOUT    = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_nota,
  input  logic             in_tom,
  input  logic             in_last,
  output logic             cls_reset,
  output logic             cls_ok,
  output logic [2:0]       cls_nota,
  output logic             cls_tom,
  input  logic             cls_fim,
  input  logic [1:0]       cls_tipo,
  output logic             word_done,
  output logic [1:0]       word_tipo,
  output logic [CNT_W-1:0] cnt_adj,
  output logic [CNT_W-1:0] cnt_comp,
  output logic [CNT_W-1:0] cnt_adv,
  output logic [CNT_W-1:0] cnt_err,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(MAX_NOTES + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [NW-1:0] NOTES_MAX = NW'(MAX_NOTES);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CLR, S_FEED, S_TERM, S_WAIT, S_DRAIN, S_REPORT
  } state_t;

  state_t state, next_state;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [4:0]    head;
  logic [2:0]    head_nota;
  logic          head_tom, head_last;
  logic [NW-1:0] notes_sent;
  logic [WW-1:0] wait_cnt;
  logic          feed_go;

  // Entry layout is {last, tom, nota}; pointers carry one extra wrap bit.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_nota = head[2:0];
  assign head_tom  = head[3];
  assign head_last = head[4];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_tom, in_nota};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A note is sent only to a live classifier, and only while it is legal inside a word.
  assign feed_go = !cls_fim && !empty && (head_nota != 3'b000) && (notes_sent != NOTES_MAX);
  assign busy    = !(state == S_FEED && notes_sent == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_CLR:    next_state = S_FEED;
      S_FEED: begin
        if (cls_fim) next_state = S_DRAIN;
        else if (!empty) begin
          if (head_nota == 3'b000 || notes_sent == NOTES_MAX) next_state = S_DRAIN;
          else if (head_last)                                 next_state = S_TERM;
        end
      end
      S_TERM:   next_state = cls_fim ? S_REPORT : S_WAIT;
      S_WAIT:   if (cls_fim || wait_cnt == WAIT_LAST) next_state = S_REPORT;
      S_DRAIN:  if (!empty && head_last) next_state = S_REPORT;
      S_REPORT: next_state = S_CLR;
      default:  next_state = S_CLR;
    endcase
  end

  always_comb begin
    cls_reset = 1'b0;
    cls_ok    = 1'b0;
    cls_nota  = 3'b000;
    cls_tom   = 1'b0;
    pop       = 1'b0;
    word_done = 1'b0;
    case (state)
      S_CLR:    cls_reset = 1'b1;
      S_FEED: begin
        if (feed_go) begin
          cls_ok   = 1'b1;
          cls_nota = head_nota;
          cls_tom  = head_tom;
          pop      = 1'b1;
        end
      end
      S_TERM:   cls_ok = !cls_fim;
      S_DRAIN:  pop = !empty;
      S_REPORT: word_done = 1'b1;
      default:  ;
    endcase
  end

  // word_tipo settles on entry to REPORT so it is valid alongside word_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      notes_sent <= '0;
      wait_cnt   <= '0;
      word_tipo  <= 2'b00;
      cnt_adj    <= '0;
      cnt_comp   <= '0;
      cnt_adv    <= '0;
      cnt_err    <= '0;
    end else begin
      case (state)
        S_CLR:  notes_sent <= '0;
        S_FEED: if (cls_ok) notes_sent <= notes_sent + NW'(1);
        S_TERM: wait_cnt <= '0;
        S_WAIT: wait_cnt <= wait_cnt + WW'(1);
        S_REPORT: begin
          case (word_tipo)
            2'b01:   if (cnt_adj  != '1) cnt_adj  <= cnt_adj  + CNT_W'(1);
            2'b10:   if (cnt_comp != '1) cnt_comp <= cnt_comp + CNT_W'(1);
            2'b11:   if (cnt_adv  != '1) cnt_adv  <= cnt_adv  + CNT_W'(1);
            default: if (cnt_err  != '1) cnt_err  <= cnt_err  + CNT_W'(1);
          endcase
        end
        default: ;
      endcase
      if (state != S_REPORT && next_state == S_REPORT)
        word_tipo <= (state == S_WAIT && cls_fim) ? cls_tipo : 2'b00;
    end
  end

endmodule

// File: tb/tb_nota_word_sequencer.sv
// tb/tb_nota_word_sequencer.sv - directed bench with a behavioural classifier model
module tb_nota_word_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_nota = 3'b000;
  logic       in_tom = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, cls_reset, cls_ok, cls_tom, word_done, busy;
  logic [2:0] cls_nota;
  logic [1:0] word_tipo;
  logic [1:0] cnt_adj, cnt_comp, cnt_adv, cnt_err;

  logic       m_fim = 1'b0;
  logic [1:0] m_tipo = 2'b00;
  int         m_cnt = 0;
  logic       m_tom = 1'b0;
  logic       mute = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         ok_cnt = 0;
  logic [31:0] log_pk = '0;
  int         last_ok_cyc = 0;
  int         done_cyc = 0;
  logic [1:0] done_q[$];

  nota_word_sequencer #(.FIFO_DEPTH(8), .MAX_NOTES(4), .TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_nota(in_nota), .in_tom(in_tom), .in_last(in_last),
    .cls_reset(cls_reset), .cls_ok(cls_ok), .cls_nota(cls_nota), .cls_tom(cls_tom),
    .cls_fim(m_fim), .cls_tipo(m_tipo),
    .word_done(word_done), .word_tipo(word_tipo),
    .cnt_adj(cnt_adj), .cnt_comp(cnt_comp), .cnt_adv(cnt_adv), .cnt_err(cnt_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Classifier: 3 notes -> adj, 4 notes -> comp if last tom=1 else adv, sol -> immediate error.
  always @(posedge clk) begin
    if (reset || cls_reset) begin
      m_fim <= 1'b0; m_tipo <= 2'b00; m_cnt <= 0; m_tom <= 1'b0;
    end else if (cls_ok) begin
      if (cls_nota == 3'b000) begin
        if (!mute) begin
          m_fim  <= 1'b1;
          m_tipo <= (m_cnt == 3) ? 2'b01 : (m_cnt == 4) ? (m_tom ? 2'b10 : 2'b11) : 2'b00;
        end
      end else begin
        m_cnt <= m_cnt + 1;
        m_tom <= cls_tom;
        if (cls_nota == 3'd5) begin m_fim <= 1'b1; m_tipo <= 2'b00; end
      end
    end
  end

  always @(negedge clk) begin
    if (cls_ok) begin
      ok_cnt++;
      log_pk = {log_pk[27:0], cls_tom, cls_nota};
      last_ok_cyc = cyc;
    end
    if (word_done) begin
      done_q.push_back(word_tipo);
      done_cyc = cyc;
    end
    if (!reset) begin
      n_checks++;
      if (cls_ok && m_fim) begin n_fail++; $display("FAIL ok_while_fim: cls_ok=%0b cls_fim=%0b, required cls_ok=0", cls_ok, m_fim); end
      n_checks++;
      if (!cls_ok && (cls_nota !== 3'b000 || cls_tom !== 1'b0)) begin
        n_fail++; $display("FAIL idle_note: nota=%0d tom=%0b, required 0/0 without ok", cls_nota, cls_tom);
      end
    end
  end

  task automatic push(input logic [2:0] n, input logic t, input logic l);
    int k = 0;
    @(negedge clk);
    in_nota = n; in_tom = t; in_last = l; in_valid = 1'b1;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (done_q.size() < n && k < 300) begin @(posedge clk); k++; end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic fresh();
    ok_cnt = 0; log_pk = '0; done_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (word_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", word_done); end
    n_checks++; if (word_tipo !== 2'b00) begin n_fail++; $display("FAIL rst_tipo: got %0b want 00", word_tipo); end
    n_checks++; if ({cnt_adj, cnt_comp, cnt_adv, cnt_err} !== 8'h00) begin n_fail++; $display("FAIL rst_cnt: got %0h want 0", {cnt_adj, cnt_comp, cnt_adv, cnt_err}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
    reset = 1'b0;
    n_checks++; if (cls_reset !== 1'b1) begin n_fail++; $display("FAIL rst_clr: got %0b want 1", cls_reset); end
    @(negedge clk);
    n_checks++; if (cls_reset !== 1'b0) begin n_fail++; $display("FAIL clr_one_cycle: got %0b want 0", cls_reset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_adj();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL adj_done: got %0d want 1", done_q.size()); end
    n_checks++; if (ok_cnt !== 4) begin n_fail++; $display("FAIL adj_oks: got %0d want 4", ok_cnt); end
    n_checks++; if (log_pk !== 32'h3460) begin n_fail++; $display("FAIL adj_notes: got %0h want 3460", log_pk); end
    n_checks++; if (word_tipo !== 2'b01) begin n_fail++; $display("FAIL adj_tipo: got %0b want 01", word_tipo); end
    n_checks++; if (cnt_adj !== 2'd1) begin n_fail++; $display("FAIL adj_cnt: got %0d want 1", cnt_adj); end
    n_checks++; if (done_cyc - last_ok_cyc !== 2) begin n_fail++; $display("FAIL adj_gap: got %0d want 2", done_cyc - last_ok_cyc); end
  endtask

  task automatic test_comp();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0); push(3'd1, 1'b1, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h34690) begin n_fail++; $display("FAIL comp1_notes: got %0h want 34690", log_pk); end
    n_checks++; if (word_tipo !== 2'b10) begin n_fail++; $display("FAIL comp1_tipo: got %0b want 10", word_tipo); end
    fresh();
    push(3'd2, 1'b0, 1'b0); push(3'd3, 1'b0, 1'b0); push(3'd7, 1'b0, 1'b0); push(3'd2, 1'b1, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h237A0) begin n_fail++; $display("FAIL comp2_notes: got %0h want 237a0", log_pk); end
    n_checks++; if (word_tipo !== 2'b10) begin n_fail++; $display("FAIL comp2_tipo: got %0b want 10", word_tipo); end
    n_checks++; if (cnt_comp !== 2'd2) begin n_fail++; $display("FAIL comp_cnt: got %0d want 2", cnt_comp); end
  endtask

  task automatic test_adv();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0); push(3'd7, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h34670) begin n_fail++; $display("FAIL adv_notes: got %0h want 34670", log_pk); end
    n_checks++; if (word_tipo !== 2'b11) begin n_fail++; $display("FAIL adv_tipo: got %0b want 11", word_tipo); end
    n_checks++; if (cnt_adv !== 2'd1) begin n_fail++; $display("FAIL adv_cnt: got %0d want 1", cnt_adv); end
  endtask

  task automatic test_fim_early();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd5, 1'b0, 1'b0); push(3'd1, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h345) begin n_fail++; $display("FAIL early_notes: got %0h want 345", log_pk); end
    n_checks++; if (word_tipo !== 2'b00) begin n_fail++; $display("FAIL early_tipo: got %0b want 00", word_tipo); end
    n_checks++; if (cnt_err !== 2'd1) begin n_fail++; $display("FAIL early_cnt: got %0d want 1", cnt_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: busy got %0b want 0", busy); end
  endtask

  task automatic test_too_long();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0);
    push(3'd7, 1'b0, 1'b0); push(3'd1, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h3467) begin n_fail++; $display("FAIL long_notes: got %0h want 3467", log_pk); end
    n_checks++; if (word_tipo !== 2'b00) begin n_fail++; $display("FAIL long_tipo: got %0b want 00", word_tipo); end
    n_checks++; if (cnt_err !== 2'd2) begin n_fail++; $display("FAIL long_cnt: got %0d want 2", cnt_err); end
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h3460) begin n_fail++; $display("FAIL after_long_notes: got %0h want 3460", log_pk); end
    n_checks++; if (cnt_adj !== 2'd2) begin n_fail++; $display("FAIL after_long_cnt: got %0d want 2", cnt_adj); end
  endtask

  task automatic test_zero_note();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd0, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h3) begin n_fail++; $display("FAIL zero_notes: got %0h want 3", log_pk); end
    n_checks++; if (cnt_err !== 2'd3) begin n_fail++; $display("FAIL zero_cnt: got %0d want 3", cnt_err); end
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0); push(3'd7, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (word_tipo !== 2'b11) begin n_fail++; $display("FAIL after_zero_tipo: got %0b want 11", word_tipo); end
    n_checks++; if (cnt_adv !== 2'd2) begin n_fail++; $display("FAIL after_zero_cnt: got %0d want 2", cnt_adv); end
  endtask

  task automatic test_timeout();
    fresh();
    mute = 1'b1;
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b1);
    wait_words(1);
    mute = 1'b0;
    n_checks++; if (log_pk !== 32'h3460) begin n_fail++; $display("FAIL tmo_notes: got %0h want 3460", log_pk); end
    n_checks++; if (word_tipo !== 2'b00) begin n_fail++; $display("FAIL tmo_tipo: got %0b want 00", word_tipo); end
    n_checks++; if (done_cyc - last_ok_cyc !== 5) begin n_fail++; $display("FAIL tmo_gap: got %0d want 5", done_cyc - last_ok_cyc); end
    n_checks++; if (cnt_err !== 2'd3) begin n_fail++; $display("FAIL tmo_sat: got %0d want 3", cnt_err); end
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd5, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h35) begin n_fail++; $display("FAIL term_fim_notes: got %0h want 35", log_pk); end
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL term_fim_done: got %0d want 1", done_q.size()); end
    n_checks++; if (cnt_err !== 2'd3) begin n_fail++; $display("FAIL err_sat: got %0d want 3", cnt_err); end
  endtask

  task automatic test_fifo_full();
    fresh();
    mute = 1'b1;
    push(3'd3, 1'b0, 1'b1);
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0); push(3'd1, 1'b1, 1'b1);
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0); push(3'd7, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", in_ready); end
    mute = 1'b0;
    wait_words(3);
    n_checks++;
    if (done_q.size() !== 3) begin n_fail++; $display("FAIL full_words: got %0d want 3", done_q.size()); end
    else if ({done_q[0], done_q[1], done_q[2]} !== 6'b00_10_11) begin
      n_fail++; $display("FAIL full_tipos: got %b want 001011", {done_q[0], done_q[1], done_q[2]});
    end
    n_checks++; if ({cnt_comp, cnt_adv} !== 4'b11_11) begin n_fail++; $display("FAIL full_cnt: got %b want 1111", {cnt_comp, cnt_adv}); end
  endtask

  task automatic test_reset_mid_word();
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (cls_reset !== 1'b1) begin n_fail++; $display("FAIL mid_clr: got %0b want 1", cls_reset); end
    n_checks++; if (done_q.size() !== 0) begin n_fail++; $display("FAIL mid_done: got %0d want 0", done_q.size()); end
    n_checks++; if ({cnt_adj, cnt_comp, cnt_adv, cnt_err, word_tipo} !== 10'h0) begin n_fail++; $display("FAIL mid_cnt: got %0h want 0", {cnt_adj, cnt_comp, cnt_adv, cnt_err, word_tipo}); end
    fresh();
    push(3'd3, 1'b0, 1'b0); push(3'd4, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b1);
    wait_words(1);
    n_checks++; if (log_pk !== 32'h3460) begin n_fail++; $display("FAIL mid_next_notes: got %0h want 3460", log_pk); end
    n_checks++; if (cnt_adj !== 2'd1 || word_tipo !== 2'b01) begin n_fail++; $display("FAIL mid_next: cnt_adj=%0d tipo=%0b want 1/01", cnt_adj, word_tipo); end
  endtask

  initial begin
    test_reset();
    test_adj();
    test_comp();
    test_adv();
    test_fim_early();
    test_too_long();
    test_zero_note();
    test_timeout();
    test_fifo_full();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
